// File: rtl/bit_count_param.sv
// bit_count_param: sequential popcount of a WIDTH-bit operand, BITS_PER_CYCLE bits per clock, s/done handshake.
// Define BIT_COUNT_PARITY_EN to add the parity output (XOR of all counted bits).
module bit_count_param #(
  parameter int WIDTH = 16,
  parameter int BITS_PER_CYCLE = 1,
  localparam int RW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s,
  input  logic             mode,
  input  logic [WIDTH-1:0] data,
  output logic [RW-1:0]    result,
`ifdef BIT_COUNT_PARITY_EN
  output logic             parity,
`endif
  output logic             done
);
  if (WIDTH < 1 || BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > WIDTH || WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_cfg
    $error("bit_count_param: invalid WIDTH/BITS_PER_CYCLE");
  end
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [RW-1:0] result_q, result_d, cnt;
  logic done_q, done_d;
`ifdef BIT_COUNT_PARITY_EN
  logic parity_q, parity_d, par;
`endif
  always_comb begin
    cnt = '0;
`ifdef BIT_COUNT_PARITY_EN
    par = 1'b0;
`endif
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      cnt = cnt + RW'(a_q[i]);
`ifdef BIT_COUNT_PARITY_EN
      par = par ^ a_q[i];
`endif
    end
    state_d = state_q;
    a_d = a_q;
    result_d = result_q;
    done_d = done_q;
`ifdef BIT_COUNT_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: if (s) begin
        a_d = mode ? ~data : data;
        result_d = '0;
`ifdef BIT_COUNT_PARITY_EN
        parity_d = 1'b0;
`endif
        state_d = S_RUN;
      end
      S_RUN: if (a_q == '0) begin
        done_d = 1'b1;
        state_d = S_DONE;
      end else begin
        result_d = result_q + cnt;
        a_d = a_q >> BITS_PER_CYCLE;
`ifdef BIT_COUNT_PARITY_EN
        parity_d = parity_q ^ par;
`endif
      end
      S_DONE: if (!s) begin
        done_d = 1'b0;
        result_d = '0;
`ifdef BIT_COUNT_PARITY_EN
        parity_d = 1'b0;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q <= '0;
      result_q <= '0;
      done_q <= 1'b0;
`ifdef BIT_COUNT_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      result_q <= result_d;
      done_q <= done_d;
`ifdef BIT_COUNT_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end
  assign result = result_q;
  assign done = done_q;
`ifdef BIT_COUNT_PARITY_EN
  assign parity = parity_q;
`endif
endmodule
